inst_prefetch: RTL
==================

# inst_prefetch

Instruction prefetch stage. Drives a req/gnt/rvalid instruction-memory port and generates sequential PCs. Buffers returned words with their PCs in a small FIFO, hands them to decode over a valid/ready handshake, and discards stale responses after a branch/jump redirect. It sits directly upstream of decode and replaces the single-register fetch path.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle; meaningful only while imem_req=1.
- imem_rvalid  in  1  read data valid; in order, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address.
- out_valid  out  1  out_pc/out_inst hold a valid instruction.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  32  PC of out_inst.
- out_inst  out  32  instruction word.
- error  out  1  sticky fault flag.

## Operation
- Registers:
  - fetch_pc: next request address.
  - rsp_pc: PC of next expected response.
  - outstanding: granted requests not yet returned, 0..MAX_OUTSTANDING.
  - drop: stale responses still to discard.
  - FIFO: DEPTH entries of {pc, inst}.
- FSM, 3 states:
  - RESET: entered while rst=1; goes to RUN on the first cycle with rst=0.
  - RUN: normal operation.
  - FLUSH: entered on redirect when drop would be nonzero; returns to RUN when drop reaches 0.
- Request rule: imem_req=1 in RUN or FLUSH when count + outstanding < DEPTH, outstanding < MAX_OUTSTANDING, and no redirect this cycle.
- imem_addr=fetch_pc. Address is held stable while req=1 and gnt=0.
- Grant (req && gnt): fetch_pc += 4 (wraps mod 2^32); outstanding++.
- Response (rvalid):
  - Always: outstanding--.
  - If drop>0: drop--, data discarded.
  - Else: push {rsp_pc, imem_rdata}; rsp_pc += 4.
- Pop: out_valid && out_ready. Output is the FIFO head.
- Simultaneous push and pop are legal. Push never overflows because space is reserved at request time.
- Redirect cycle:
  - FIFO cleared; out_valid=0 next cycle.
  - fetch_pc and rsp_pc set to redirect_pc.
  - drop = outstanding + (req&&gnt this cycle) − (rvalid this cycle && drop was 0 ? 1 : 0) + existing drop adjustments.
  - Equivalently, every request granted at or before the redirect cycle is dropped.
  - A pop in the same cycle is discarded.
  - A pending un-granted req is withdrawn; imem must tolerate withdrawal.
- Protocol fault: rvalid while outstanding=0 sets error. The response is ignored.
- Reset mid-operation: all state cleared. Responses arriving after reset are protocol faults; the integrator guarantees imem is reset together with this block.

## Timing
- Values during reset:
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0, error=0.
  - outstanding=0, drop=0, FIFO empty.
- First imem_req is asserted in the first cycle after rst deasserts.
- rvalid in cycle M makes out_valid=1 in cycle M+1 (registered FIFO, no bypass).
- Redirect in cycle N: imem_req with addr=redirect_pc in cycle N+1.
- With gnt in N+1 and rvalid in N+2, out_valid rises in N+3. Stale responses delay this by one cycle each.
- Sustained throughput is 1 instruction/cycle when gnt=1 and rvalid follows one cycle after gnt.

## Configuration
- Macro: PREFETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]≠0 sets error; error is sticky until rst.
  - The redirect is still taken with bits [1:0] forced to 0.
- Undefined:
  - No alignment check; bits [1:0] are always forced to 0.
  - error reflects only protocol faults.

## Structure
- Shared package (common):
  - localparam MAX_OUTSTANDING = 2.
  - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} FetchEntry.
  - FSM state enum PrefetchState {PF_RESET, PF_RUN, PF_FLUSH}.
- Sub-module: sync_fifo (parameterised DEPTH, FetchEntry data, flush input, count output).
- PC, outstanding and drop logic stays in inst_prefetch.

## Test plan
- Reset, then gnt=1 every cycle and rvalid one cycle after each gnt, out_ready=1 → imem_addr sequence 0,4,8,…; out_pc 0,4,8 with matching out_inst, one per cycle from cycle 3.
- out_ready=0 held → exactly DEPTH=4 words are buffered, imem_req drops to 0, and no overflow occurs. Releasing ready drains all 4 in order, then fetching resumes.
- Redirect to 0x100 with 2 requests outstanding → the next 2 rvalids are discarded, the FSM passes through FLUSH, and the first out_pc is 0x100.
- gnt held 0 for 5 cycles → imem_req stays 1 with imem_addr constant. On gnt, the address advances by 4.
- rvalid asserted with nothing outstanding → error=1 and stays 1 until rst; FIFO unchanged.
- With PREFETCH_ALIGN_CHECK_EN, redirect to 0x102 → error=1 and imem_addr=0x100. Without the macro, the same stimulus gives error=0 and imem_addr=0x100.

Source files
------------

// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// Used by inst_prefetch and its sync_fifo buffer.
package inst_prefetch_pkg;

    localparam int MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FetchEntry;

    typedef enum logic [1:0] {
        PF_RESET = 2'd0,
        PF_RUN   = 2'd1,
        PF_FLUSH = 2'd2
    } PrefetchState;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_prefetch_sync_fifo.sv
// Small synchronous FIFO of FetchEntry words with a single-cycle flush.
// Output is the registered head entry; there is no write-to-read bypass.
module sync_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  FetchEntry              push_data,
    input  logic                   pop,
    output FetchEntry              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    FetchEntry         mem_q [DEPTH];
    FetchEntry         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch stage: sequential fetch over req/gnt/rvalid, buffered
// hand-off to decode, stale-response dropping after redirects.
// Optional PREFETCH_ALIGN_CHECK_EN flags misaligned redirect targets as errors.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        error
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    PrefetchState  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [1:0]    outstanding_q, outstanding_d;
    logic [1:0]    drop_q, drop_d;
    logic          error_q, error_d;

    FetchEntry     fifo_head;
    FetchEntry     fifo_wdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;
    logic          has_room;
    logic          grant;
    logic          rsp_accept;
    logic          proto_fault;
    logic [31:0]   redirect_target;

    assign redirect_target = word_align(redirect_pc);

`ifdef PREFETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_align_bits;
    assign unused_align_bits = ^redirect_pc[1:0];
`endif

    // FIFO space is reserved when a request goes out, so pushes never overflow.
    assign has_room    = (SW'(fifo_count) + SW'(outstanding_q)) < SW'(DEPTH);
    assign imem_req    = !rst && !redirect_valid && has_room
                         && (outstanding_q < 2'(MAX_OUTSTANDING));
    assign imem_addr   = fetch_pc_q;
    assign grant       = imem_req && imem_gnt;
    assign rsp_accept  = imem_rvalid && (outstanding_q != 2'd0);
    assign proto_fault = imem_rvalid && (outstanding_q == 2'd0);

    assign out_valid   = (fifo_count != '0);
    assign fifo_push   = rsp_accept && (drop_q == 2'd0) && !redirect_valid;
    assign fifo_pop    = out_valid && out_ready && !redirect_valid;
    assign fifo_wdata  = '{pc: rsp_pc_q, inst: imem_rdata};

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .push_data(fifo_wdata),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + 2'(grant) - 2'(rsp_accept);
        drop_d        = drop_q;
        error_d       = error_q | proto_fault;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_accept && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end
        if (fifo_push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end

        case (state_q)
            PF_RESET: state_d = PF_RUN;
            PF_FLUSH: if (drop_d == 2'd0) state_d = PF_RUN;
            default:  state_d = PF_RUN;
        endcase

        // Every request still in flight after this cycle predates the redirect.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != 2'd0) ? PF_FLUSH : PF_RUN;
`ifdef PREFETCH_ALIGN_CHECK_EN
            if (misaligned) begin
                error_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PF_RESET;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_q        <= 2'd0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            error_q       <= error_d;
        end
    end

    assign out_pc   = out_valid ? fifo_head.pc : 32'h0;
    assign out_inst = out_valid ? fifo_head.inst : 32'h0;
    assign error    = error_q;

endmodule
